// File: rtl/activation_pkg.sv
// Shared types and constants for the activation quantizer and its lane math.
// Latency: none (package only).
// Backpressure: not applicable.
package activation_pkg;

    // Activation selection. The encoding matches the cfg_mode port; 2'b11 is
    // folded to ACT_NONE when the config is latched.
    typedef enum logic [1:0] {
        ACT_NONE  = 2'b00,
        ACT_RELU  = 2'b01,
        ACT_LEAKY = 2'b10
    } act_mode_t;

    localparam int OUT_MAX     = 127;
    localparam int OUT_MIN     = -128;
    localparam int LEAKY_SHIFT = 3;

endpackage

// File: rtl/act_lane.sv
// Single-lane math: rounded requantize shift (stage 1) and activation plus int8 saturation (stage 2).
// Latency: purely combinational; the top module registers both results.
// Backpressure: none; the two paths are independent and hold no state.
//
// Ports:
//   x_i     raw signed input lane        -> y_o  rounded, shifted value (IN_W+1 bits)
//   shift_i requantization right shift
//   y_i     registered stage-1 value     -> q_o  activated, saturated output lane
//   mode_i  activation selection
module act_lane
    import activation_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
) (
    input  logic [IN_W-1:0]  x_i,
    input  logic [3:0]       shift_i,
    output logic [IN_W:0]    y_o,
    input  logic [IN_W:0]    y_i,
    input  act_mode_t        mode_i,
    output logic [OUT_W-1:0] q_o
);

    localparam int RW = IN_W + 1;

    logic signed [RW-1:0] xe;
    logic signed [RW-1:0] rnd;
    logic signed [RW-1:0] yi;
    logic signed [RW-1:0] act;
    int                   act_int;

    // One extra bit of headroom keeps x + 2^(s-1) from overflowing at the
    // positive end of the input range.
    always_comb begin
        xe  = {x_i[IN_W-1], x_i};
        rnd = '0;
        if (shift_i != 4'd0) begin
            rnd = RW'(1) << (shift_i - 4'd1);
        end
        y_o = (xe + rnd) >>> shift_i;
    end

    always_comb begin
        yi  = y_i;
        act = yi;
        case (mode_i)
            ACT_RELU: begin
                if (yi[RW-1]) act = '0;
            end
            ACT_LEAKY: begin
                // Arithmetic shift floors toward -inf, which is the intended slope.
                if (yi[RW-1]) act = yi >>> LEAKY_SHIFT;
            end
            default: ;
        endcase
        act_int = int'(act);
        if (act_int > OUT_MAX) begin
            q_o = OUT_W'(OUT_MAX);
        end else if (act_int < OUT_MIN) begin
            q_o = OUT_W'(OUT_MIN);
        end else begin
            q_o = OUT_W'(act_int);
        end
    end

endmodule

// File: rtl/activation_quantizer.sv
// Requantizes N bias-added lanes per beat, applies none/ReLU/leaky activation, saturates to int8, tags tile ends.
// Latency: two cycles from input accept to out_valid; one beat per cycle sustained.
// Backpressure: full valid/ready; each stage advances only when the next is empty or draining this cycle.
//
// Ports:
//   clk, n_rst                      clock and async active-low reset
//   cfg_load/cfg_mode/cfg_shift     config load, accepted only when idle and in_valid=0
//   cfg_err                         one-cycle pulse for a rejected load
//   in_valid/in_ready/in_data       upstream beat, lane0 at LSBs
//   out_valid/out_ready/out_data    downstream beat, int8 lanes
//   out_last                        final beat of a ROWS-beat tile
//   busy                            either pipeline stage occupied
module activation_quantizer
    import activation_pkg::*;
#(
    parameter int N     = 8,
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int ROWS  = 8
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               cfg_load,
    input  logic [1:0]         cfg_mode,
    input  logic [3:0]         cfg_shift,
    output logic               cfg_err,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*IN_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*OUT_W-1:0] out_data,
    output logic               out_last,
    output logic               busy
);

    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                     s1_vld_q, s1_vld_d;
    logic [N-1:0][IN_W:0]     s1_dat_q, s1_dat_d, s1_calc;
    logic                     out_vld_q, out_vld_d;
    logic [N-1:0][OUT_W-1:0]  out_dat_q, out_dat_d, s2_calc;
    logic [CW-1:0]            cnt_q, cnt_d;
    act_mode_t                mode_q, mode_d;
    logic [3:0]               shift_q, shift_d;
    logic                     cfg_err_q, cfg_err_d;

    logic s2_free;
    logic cfg_ok;
    logic last_row;

    for (genvar g = 0; g < N; g++) begin : g_lane
        act_lane #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W)
        ) u_lane (
            .x_i     (in_data[g*IN_W +: IN_W]),
            .shift_i (shift_q),
            .y_o     (s1_calc[g]),
            .y_i     (s1_dat_q[g]),
            .mode_i  (mode_q),
            .q_o     (s2_calc[g])
        );
    end

    // Output stage can take a beat when empty or when its beat leaves this cycle.
    assign s2_free   = !out_vld_q || out_ready;
    assign in_ready  = !s1_vld_q || s2_free;
    assign busy      = s1_vld_q || out_vld_q;
    assign cfg_ok    = cfg_load && !busy && !in_valid;
    assign last_row  = (cnt_q == CW'(ROWS - 1));

    assign out_valid = out_vld_q;
    assign out_data  = out_dat_q;
    assign out_last  = out_vld_q && last_row;
    assign cfg_err   = cfg_err_q;

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_dat_d  = s1_dat_q;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        shift_d   = shift_q;
        cfg_err_d = cfg_load && !cfg_ok;

        if (in_ready) begin
            s1_vld_d = in_valid;
            if (in_valid) s1_dat_d = s1_calc;
        end

        // Data only moves when a beat enters, so a stalled output stays put.
        if (s2_free) begin
            out_vld_d = s1_vld_q;
            if (s1_vld_q) out_dat_d = s2_calc;
        end

        // A load can only be accepted with the pipe empty, so it never
        // coincides with an output transfer.
        if (cfg_ok) begin
            mode_d  = (cfg_mode == 2'b11) ? ACT_NONE : act_mode_t'(cfg_mode);
            shift_d = cfg_shift;
            cnt_d   = '0;
        end else if (out_vld_q && out_ready) begin
            cnt_d = last_row ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_vld_q  <= 1'b0;
            s1_dat_q  <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            cnt_q     <= '0;
            mode_q    <= ACT_NONE;
            shift_q   <= 4'd0;
            cfg_err_q <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_dat_q  <= s1_dat_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            shift_q   <= shift_d;
            cfg_err_q <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_activation_quantizer.sv
// Self-checking bench for activation_quantizer: directed vectors plus randomized streams vs an arithmetic model.
// Latency: drives inputs #1 after posedge, samples handshakes and outputs at negedge.
// Backpressure: out_ready is held low or toggled randomly to exercise stalls.
module tb_activation_quantizer;

    localparam int N     = 8;
    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int ROWS  = 4;

    logic               clk = 1'b0;
    logic               n_rst;
    logic               cfg_load;
    logic [1:0]         cfg_mode;
    logic [3:0]         cfg_shift;
    logic               cfg_err;
    logic               in_valid;
    logic               in_ready;
    logic [N*IN_W-1:0]  in_data;
    logic               out_valid;
    logic               out_ready;
    logic [N*OUT_W-1:0] out_data;
    logic               out_last;
    logic               busy;

    activation_quantizer #(
        .N     (N),
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .ROWS  (ROWS)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .cfg_load  (cfg_load),
        .cfg_mode  (cfg_mode),
        .cfg_shift (cfg_shift),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    int          m_mode  = 0;
    int          m_shift = 0;
    int          m_cnt   = 0;
    bit          acc, oxf;
    bit          hold_prev = 1'b0;
    logic [63:0] hold_dat;
    logic        hold_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    // Reference: round-half-up division by 2^s, activation, clamp to int8.
    function automatic int model_lane(input int x);
        int y;
        y = (m_shift == 0) ? x : floor_div(x + (1 << (m_shift - 1)), 1 << m_shift);
        if (y < 0) begin
            if (m_mode == 1) y = 0;
            else if (m_mode == 2) y = floor_div(y, 8);
        end
        if (y > 127) y = 127;
        if (y < -128) y = -128;
        return y;
    endfunction

    function automatic logic [63:0] model_beat(input logic [N*IN_W-1:0] d);
        logic [63:0] r;
        int x, y;
        r = '0;
        for (int i = 0; i < N; i++) begin
            x = int'($signed(d[i*IN_W +: IN_W]));
            y = model_lane(x);
            r[i*OUT_W +: OUT_W] = y[OUT_W-1:0];
        end
        return r;
    endfunction

    function automatic logic [N*IN_W-1:0] rand_beat();
        logic [N*IN_W-1:0] b;
        int v;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 65535)) - 32768;
            else v = int'($urandom_range(0, 1200)) - 600;
            b[i*IN_W +: IN_W] = v[IN_W-1:0];
        end
        return b;
    endfunction

    // One clock: observe handshakes at negedge, score outputs, return #1 after posedge.
    task automatic cycle();
        logic [63:0] e;
        @(negedge clk);
        acc = in_valid && in_ready;
        oxf = out_valid && out_ready;
        if (hold_prev) begin
            check("hold_dat", out_data, hold_dat);
            check("hold_last", out_last, hold_last);
        end
        if (!out_valid) check("last_idle", out_last, 1'b0);
        if (oxf) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("out_dat", out_data, e);
                check("out_last", out_last, m_cnt == ROWS - 1);
                m_cnt = (m_cnt + 1) % ROWS;
            end
        end
        if (acc) exp_q.push_back(model_beat(in_data));
        hold_prev = out_valid && !out_ready;
        hold_dat  = out_data;
        hold_last = out_last;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && (busy || exp_q.size() != 0); i++) cycle();
        check("drain", busy || (exp_q.size() != 0), 1'b0);
    endtask

    task automatic do_cfg(input int mode, input int sh);
        wait_idle();
        cfg_load  = 1'b1;
        cfg_mode  = mode[1:0];
        cfg_shift = sh[3:0];
        cycle();
        cfg_load = 1'b0;
        check("cfg_err_ok", cfg_err, 1'b0);
        m_mode  = (mode == 3) ? 0 : mode;
        m_shift = sh;
        m_cnt   = 0;
    endtask

    task automatic vec_test(input string tag, input int mode, input int sh,
                            input int x[4], input int e[4]);
        logic [N*IN_W-1:0] b;
        do_cfg(mode, sh);
        b = rand_beat();
        for (int i = 0; i < 4; i++) b[i*IN_W +: IN_W] = IN_W'(x[i]);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = b;
        cycle();
        in_valid = 1'b0;
        check({tag, "_lat1"}, out_valid, 1'b0);
        cycle();
        check({tag, "_lat2"}, out_valid, 1'b1);
        for (int i = 0; i < 4; i++)
            check({tag, "_lane"}, 64'($signed(out_data[i*OUT_W +: OUT_W])), 64'(e[i]));
        wait_idle();
    endtask

    task automatic stream(input int total, input bit rnd);
        int sent  = 0;
        int guard = 0;
        in_valid = 1'b1;
        in_data  = rand_beat();
        while (sent < total && guard < 2000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
            guard++;
            if (acc) begin
                sent++;
                in_data = rand_beat();
            end
            if (acc || !in_valid)
                in_valid = (sent < total) && (!rnd || $urandom_range(0, 3) != 0);
        end
        check("stream_done", sent, total);
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, outs;
        n_rst     = 1'b0;
        cfg_load  = 1'b0;
        cfg_mode  = 2'b00;
        cfg_shift = 4'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_busy", busy, 1'b0);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("rst_out_last", out_last, 1'b0);

        // Directed vectors
        vec_test("none_s4", 0, 4, '{296, -40, 32767, -32768}, '{19, -2, 127, -128});
        vec_test("relu_s0", 1, 0, '{-5, 100, 300, -300}, '{0, 100, 127, 0});
        vec_test("leaky_s0", 2, 0, '{-16, -1, -2000, 50}, '{-2, -1, -128, 50});

        // Back-pressure: 5 beats against a 6-cycle stall
        do_cfg(1, 2);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = rand_beat();
        sent      = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (acc) begin
                sent++;
                in_data = rand_beat();
            end
            in_valid = (sent < 5);
        end
        check("bp_accepts", sent, 2);
        check("bp_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        outs      = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (oxf) outs++;
            if (acc) begin
                sent++;
                in_data = rand_beat();
            end
            in_valid = (sent < 5);
        end
        check("bp_burst", outs, 5);
        check("bp_sent", sent, 5);
        wait_idle();

        // Tile marking with random back-pressure
        do_cfg(0, 0);
        stream(9, 1'b1);
        wait_idle();
        check("row_cnt_end", 64'(dut.cnt_q), 64'd1);

        // Random streams in every mode, including the 2'b11 alias
        for (int m = 0; m < 4; m++) begin
            do_cfg(m, int'($urandom_range(0, 15)));
            stream(12, 1'b1);
        end

        // Rejected config while busy leaves the mode untouched
        do_cfg(2, 1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = rand_beat();
        cycle();
        in_valid  = 1'b0;
        cfg_load  = 1'b1;
        cfg_mode  = 2'b01;
        cfg_shift = 4'd7;
        cycle();
        cfg_load = 1'b0;
        check("cfg_err_busy", cfg_err, 1'b1);
        cycle();
        check("cfg_err_pulse", cfg_err, 1'b0);
        wait_idle();
        // Load together with in_valid is rejected as well
        in_valid = 1'b1;
        in_data  = rand_beat();
        cfg_load = 1'b1;
        cycle();
        cfg_load = 1'b0;
        in_valid = 1'b0;
        check("cfg_err_inv", cfg_err, 1'b1);
        stream(3, 1'b0);
        wait_idle();

        // Reset in the middle of a stream
        do_cfg(0, 3);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = rand_beat();
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (acc) in_data = rand_beat();
        end
        out_ready = 1'b0;
        cycle();
        n_rst = 1'b0;
        #2;
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_out_data", out_data, '0);
        check("mrst_out_last", out_last, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_cfg_err", cfg_err, 1'b0);
        exp_q.delete();
        hold_prev = 1'b0;
        m_mode    = 0;
        m_shift   = 0;
        m_cnt     = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_cnt", 64'(dut.cnt_q), 64'd0);
        check("mrst_in_ready", in_ready, 1'b1);
        stream(4, 1'b0);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/activation_quantizer.md
Name: activation_quantizer

Overview:
- Stage directly downstream of bias_adder; consumes one row of N signed bias-added accumulator lanes per beat.
- Per lane: requantizes by a configurable right shift with rounding, applies the selected activation (none / ReLU / leaky ReLU), and saturates to int8.
- Two-stage valid/ready pipeline with full back-pressure; the output feeds the output buffer / writeback stage.
- Tags the last beat of each tile with out_last, using a row counter.

Parameters:
- N, 8, lanes per beat.
- IN_W, 16, signed input lane width from bias_adder.
- OUT_W, 8, signed output lane width.
- ROWS, 8, beats per tile; sets the out_last period.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous active-low reset.
- cfg_load  input  1  config load pulse.
- cfg_mode  input  2  00 none, 01 ReLU, 10 leaky, 11 treated as none.
- cfg_shift  input  4  requantization right shift, 0..15.
- cfg_err  output  1  one-cycle pulse: cfg_load was rejected.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  this block accepts data.
- in_data  input  N*IN_W  packed signed lanes, lane0 at LSBs.
- out_valid  output  1  output data valid.
- out_ready  input  1  downstream accepts data.
- out_data  output  N*OUT_W  packed signed int8 lanes.
- out_last  output  1  marks the final beat of a tile.
- busy  output  1  either pipeline stage occupied.

Behaviour:
- Reset (async, n_rst=0): all of the following clear.
  - out_valid=0, out_data=0, out_last=0, cfg_err=0, busy=0.
  - Stage valids=0, row counter=0, mode=00, shift=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Handshake:
  - Transfer occurs when valid&&ready.
  - A stage advances when the next stage is empty or is being consumed in the same cycle.
  - in_ready = !s1_valid || s1_advance.
  - out_data and out_last stay stable while out_valid=1 && out_ready=0.
- Latency and throughput:
  - Two cycles from input accept to out_valid, with out_ready high.
  - One beat per cycle sustained.
  - No bubbles when out_ready=1; no beat lost or duplicated.
- Stage 1 (per lane, rounded shift, computed at IN_W+1 bits):
  - s=0: y=x.
  - s>0: y=(x + 2^(s-1)) >>> s, i.e. round half toward +inf.
  - The result is registered.
- Stage 2 (per lane):
  - ReLU: y<0 gives 0.
  - Leaky: y<0 gives y>>>3 (floor).
  - Then saturate to [-128,127]; registered to out_data.
- Config:
  - cfg_load is accepted only when busy=0 and in_valid=0.
  - On accept: latch mode and shift; clear the row counter.
  - Otherwise: ignore the load and pulse cfg_err for one cycle.
  - Config never changes mid-tile.
- Row counter:
  - Increments on each output transfer (out_valid&&out_ready).
  - out_last=1 when the counter equals ROWS-1 while out_valid=1.
  - Wraps to 0 after that transfer.
- Simultaneous events:
  - An input accept and an output transfer in the same cycle are legal; occupancy is unchanged.
  - A cfg_load in the same cycle as in_valid is rejected.
- Mid-operation reset discards in-flight beats and all of the above clears.

Decomposition:
- Package activation_pkg holds:
  - the act_mode_t enum (ACT_NONE, ACT_RELU, ACT_LEAKY);
  - localparams OUT_MAX=127, OUT_MIN=-128, LEAKY_SHIFT=3.
- One sub-module, act_lane: purely combinational single-lane stage-1/stage-2 math, instantiated N times in a generate loop.
- Pipeline registers, handshake and row counter live in the top module.

Test Plan:
1. Reset: n_rst low for two cycles, then high -> out_valid=0, out_data=0, busy=0, in_ready=1, cfg_err=0.
2. Mode none, shift=4; lanes 296, -40, 32767, -32768 -> after two cycles, out lanes 19, -2, 127, -128.
3. ReLU, shift=0; lanes -5, 100, 300, -300 -> 0, 100, 127, 0. Leaky, shift=0; lanes -16, -1, -2000, 50 -> -2, -1, -128, 50.
4. Back-pressure: stream 5 beats with out_ready low for 6 cycles ->
   - in_ready drops after 2 accepts;
   - out_data is held stable;
   - after release, all 5 beats emerge in order, one per cycle.
5. ROWS=4, stream 9 beats with out_ready toggling randomly -> out_last on output beats 4 and 8 only; counter=1 at the end.
6. cfg_load while busy -> cfg_err pulses one cycle and mode is unchanged. Reset asserted mid-stream -> outputs clear and the counter is 0; a fresh 4-beat tile gives out_last on beat 4.
